// File: rtl/req_arbiter.sv
// ---------------------------------------------------------------------------
// req_arbiter
//
// Four-requester round-robin arbiter with a bounded hold time. A requester
// keeps the grant while it keeps requesting, up to MAX_HOLD cycles. After
// that the grant is revoked and a one-cycle timeout pulse is raised. Every
// grant is followed by one dead (GAP) cycle before the next grant can be
// issued.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   req        in   4  level-sensitive request lines, one per requester
//   gnt        out  4  registered one-hot grant, 0000 when idle
//   gnt_idx    out  2  registered binary index of the gnt bit, 00 when idle
//   gnt_valid  out  1  high whenever gnt is non-zero
//   timeout    out  1  one-cycle pulse in the GAP cycle after a forced revoke
// ---------------------------------------------------------------------------
module req_arbiter #(
  parameter int unsigned MAX_HOLD = 8  // legal range 2..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Sized so MAX_HOLD itself is representable; the counter stops there.
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [1:0]       r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_idx;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [1:0]       r_ptr;

  logic [7:0]       w_req_dbl;
  logic [2:0]       w_sh;
  logic [3:0]       w_rot;
  logic [1:0]       w_win_ofs;
  logic [1:0]       w_win_idx;
  logic             w_win_valid;
  logic             w_owner_req;
  logic             w_hold_max;

  // Rotate req so that bit 0 is the requester right after the last winner;
  // a plain priority encode on the rotated vector then gives round-robin.
  assign w_req_dbl = {req, req};
  assign w_sh      = {1'b0, r_ptr} + 3'd1;
  assign w_rot     = w_req_dbl[w_sh +: 4];

  // NOTE: every signal written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_win_valid = |req;
    w_win_ofs   = 2'd0;
    if (w_rot[0])      w_win_ofs = 2'd0;
    else if (w_rot[1]) w_win_ofs = 2'd1;
    else if (w_rot[2]) w_win_ofs = 2'd2;
    else               w_win_ofs = 2'd3;
    w_win_idx = r_ptr + 2'd1 + w_win_ofs;  // wraps mod 4
  end

  assign w_owner_req = req[r_gnt_idx];
  assign w_hold_max  = (r_hold_cnt == CNT_W'(MAX_HOLD));

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= 4'b0000;
      r_gnt_idx   <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
      r_ptr       <= 2'd3;  // requester 0 searched first after reset
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_win_valid) begin
            r_state     <= S_BUSY;
            r_gnt       <= 4'b0001 << w_win_idx;
            r_gnt_idx   <= w_win_idx;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= CNT_W'(1);
          end else begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
          end
        end
        S_BUSY: begin
          if (!w_owner_req || w_hold_max) begin
            r_state     <= S_GAP;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_ptr       <= r_gnt_idx;
            // A release on the limit edge is a normal release, not a timeout.
            r_timeout   <= w_owner_req;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= 4'b0000;
          r_gnt_idx   <= 2'd0;
          r_gnt_valid <= 1'b0;
          r_hold_cnt  <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_arbiter
//
// Directed scenarios followed by a long random run. Each cycle the outputs
// are compared with a reference model that tracks only "who owns the grant,
// for how long, and who owned it last", applying the arbitration rules
// directly with modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_req_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec;
  int n_err;

  // Reference model state.
  int m_owner;  // -1 when nobody holds the grant
  int m_held;   // grant cycles so far for the current owner
  int m_last;   // last requester that held the grant
  bit m_to;     // timeout expected in the current cycle

  req_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic [3:0] r, input logic rs);
    int c;
    if (rs) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_to    = 1'b0;
    end else if (m_owner >= 0) begin
      m_to = 1'b0;
      if (!r[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        m_last  = m_owner;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_to = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (r[c]) begin
          m_owner = c;
          m_held  = 1;
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("gnt_idx",   32'(gnt_idx),   32'(e_idx));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("timeout",   32'(timeout),   32'(m_to));
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    check_model();
  endtask

  initial begin
    logic [3:0] r;
    int         q[$];
    n_vec   = 0;
    n_err   = 0;
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_to    = 1'b0;
    req     = 4'b0000;
    rst     = 1'b1;

    // Reset state.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_valid", 32'(gnt_valid), 32'h0);

    // Basic grant, release, GAP, next requester.
    step(4'b0101, 1'b0);
    chk("b_first_gnt", 32'(gnt), 32'h1);
    step(4'b0100, 1'b0);
    chk("b_gap_gnt", 32'(gnt), 32'h0);
    step(4'b0100, 1'b0);
    chk("b_second_gnt", 32'(gnt), 32'h4);
    chk("b_second_idx", 32'(gnt_idx), 32'h2);

    // All requesting, each owner releases after two grant cycles.
    step(4'b0000, 1'b1);
    r = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      step(r, 1'b0);
      if (gnt != 4'b0000 && m_held == 1) q.push_back(int'(gnt_idx));
      r = (m_owner >= 0 && m_held == 2) ? (4'b1111 & ~4'(1 << m_owner))
                                        : 4'b1111;
    end
    chk("rr_count", 32'(q.size() >= 5), 32'h1);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(q[i]), 32'(i % 4));

    // Single requester held: 8 cycles, timeout GAP, re-grant.
    step(4'b0000, 1'b1);
    for (int i = 1; i <= MAX_HOLD; i++) begin
      step(4'b0010, 1'b0);
      chk("hold_gnt", 32'(gnt), 32'h2);
    end
    step(4'b0010, 1'b0);
    chk("to_gap_gnt", 32'(gnt), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    step(4'b0010, 1'b0);
    chk("to_regrant", 32'(gnt), 32'h2);
    chk("to_clear", 32'(timeout), 32'h0);

    // Two requesters that never drop alternate via timeout.
    step(4'b0000, 1'b1);
    for (int i = 1; i <= 2 * MAX_HOLD + 3; i++) begin
      step(4'b1010, 1'b0);
      if (i <= MAX_HOLD)                      chk("alt_a", 32'(gnt), 32'h2);
      else if (i == MAX_HOLD + 1)             chk("alt_to1", 32'(timeout), 32'h1);
      else if (i <= 2 * MAX_HOLD + 1)         chk("alt_b", 32'(gnt), 32'h8);
      else if (i == 2 * MAX_HOLD + 2)         chk("alt_to2", 32'(timeout), 32'h1);
      else                                    chk("alt_a2", 32'(gnt), 32'h2);
    end

    // Release on the same edge the limit is reached: no timeout.
    step(4'b0000, 1'b1);
    for (int i = 1; i <= MAX_HOLD; i++) step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("edge_rel_gnt", 32'(gnt), 32'h0);
    chk("edge_rel_to", 32'(timeout), 32'h0);

    // Reset in the middle of a grant.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("mid_pre_gnt", 32'(gnt), 32'h4);
    step(4'b1100, 1'b1);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_idx", 32'(gnt_idx), 32'h0);
    chk("mid_rst_to", 32'(timeout), 32'h0);
    step(4'b1100, 1'b0);
    chk("mid_first", 32'(gnt), 32'h4);

    // Random run with sticky request bits and occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      r = r ^ 4'($urandom & $urandom & $urandom);
      step(r, ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
